// File: rtl/retire_trace_fifo.sv
// retire_trace_fifo: DEPTH-entry trace FIFO behind the hart retire port,
// with 64-bit cycle/instret counters, drop accounting and halt tracking.
// Ports: i_clk/i_rst_n/i_clr; i_retire_* capture side; o_trace_* with
// o_trace_valid/i_trace_ready drain side; o_cycle_cnt, o_instret_cnt,
// o_drop_cnt, o_overflow, o_halted, o_done status.
// Optional: define RETIRE_TRACE_RS_EN to add rs1/rs2 addr/data fields.
module retire_trace_fifo #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_retire_valid,
  input  logic [31:0]       i_retire_pc,
  input  logic [31:0]       i_retire_inst,
  input  logic [4:0]        i_retire_rd_waddr,
  input  logic [31:0]       i_retire_rd_wdata,
  input  logic              i_retire_trap,
  input  logic              i_retire_halt,
`ifdef RETIRE_TRACE_RS_EN
  input  logic [4:0]        i_retire_rs1_raddr,
  input  logic [4:0]        i_retire_rs2_raddr,
  input  logic [31:0]       i_retire_rs1_rdata,
  input  logic [31:0]       i_retire_rs2_rdata,
  output logic [4:0]        o_trace_rs1_raddr,
  output logic [4:0]        o_trace_rs2_raddr,
  output logic [31:0]       o_trace_rs1_rdata,
  output logic [31:0]       o_trace_rs2_rdata,
`endif
  output logic              o_trace_valid,
  input  logic              i_trace_ready,
  output logic [31:0]       o_trace_pc,
  output logic [31:0]       o_trace_inst,
  output logic [31:0]       o_trace_rd_wdata,
  output logic [4:0]        o_trace_rd_waddr,
  output logic              o_trace_trap,
  output logic              o_trace_halt,
  output logic [63:0]       o_cycle_cnt,
  output logic [63:0]       o_instret_cnt,
  output logic [DROP_W-1:0] o_drop_cnt,
  output logic              o_overflow,
  output logic              o_halted,
  output logic              o_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        trap;
    logic        halt;
`ifdef RETIRE_TRACE_RS_EN
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
`endif
  } ent_t;

  typedef enum logic {
    RUN,
    HALTED
  } st_t;

  st_t st, st_nxt;

  ent_t mem [DEPTH];
  ent_t w_ent;
  ent_t hd;

  logic [AW-1:0] head, tail;
  logic [CW-1:0] cnt;
  logic [63:0] cyc, ins;
  logic [DROP_W-1:0] drp;
  logic ovf;

  logic halted, full, empty;
  logic acc, push, pop, drop;

  assign halted = (st == HALTED);
  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);

  assign acc  = i_retire_valid && !halted;
  assign pop  = !empty && i_trace_ready;
  assign push = acc && (!full || pop);
  assign drop = acc && full && !pop;

  always_comb begin
    st_nxt = st;
    unique case (st)
      RUN:    if (acc && i_retire_halt) st_nxt = HALTED;
      HALTED: st_nxt = HALTED;
      default: st_nxt = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   st <= RUN;
    else if (i_clr) st <= RUN;
    else            st <= st_nxt;
  end

  always_comb begin
    w_ent      = '0;
    w_ent.pc   = i_retire_pc;
    w_ent.inst = i_retire_inst;
    w_ent.rd   = i_retire_rd_waddr;
    w_ent.wd   = i_retire_rd_wdata;
    w_ent.trap = i_retire_trap;
    w_ent.halt = i_retire_halt;
`ifdef RETIRE_TRACE_RS_EN
    w_ent.rs1a = i_retire_rs1_raddr;
    w_ent.rs2a = i_retire_rs2_raddr;
    w_ent.rs1d = i_retire_rs1_rdata;
    w_ent.rs2d = i_retire_rs2_rdata;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_clr) mem[tail] <= w_ent;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      cyc  <= '0;
      ins  <= '0;
      drp  <= '0;
      ovf  <= 1'b0;
    end else if (i_clr) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      cyc  <= '0;
      ins  <= '0;
      drp  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      unique case (1'b1)
        push && !pop: cnt <= cnt + CW'(1);
        pop && !push: cnt <= cnt - CW'(1);
        default: ;
      endcase
      if (!halted) cyc <= cyc + 64'd1;
      if (acc)     ins <= ins + 64'd1;
      if (drop) begin
        ovf <= 1'b1;
        if (drp != '1) drp <= drp + DROP_W'(1);
      end
    end
  end

  // Gate the head read so every output is 0 while empty (incl. reset).
  assign hd = empty ? '0 : mem[head];

  assign o_trace_valid    = !empty;
  assign o_trace_pc       = hd.pc;
  assign o_trace_inst     = hd.inst;
  assign o_trace_rd_waddr = hd.rd;
  assign o_trace_rd_wdata = hd.wd;
  assign o_trace_trap     = hd.trap;
  assign o_trace_halt     = hd.halt;
`ifdef RETIRE_TRACE_RS_EN
  assign o_trace_rs1_raddr = hd.rs1a;
  assign o_trace_rs2_raddr = hd.rs2a;
  assign o_trace_rs1_rdata = hd.rs1d;
  assign o_trace_rs2_rdata = hd.rs2d;
`endif

  assign o_cycle_cnt   = cyc;
  assign o_instret_cnt = ins;
  assign o_drop_cnt    = drp;
  assign o_overflow    = ovf;
  assign o_halted      = halted;
  assign o_done        = halted && empty;

endmodule
